cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
- Sequencer for the two-level cache read-miss path: L1 (4-word lines) backed by L2 (8-word lines, 8 sets, tag addr[31:6], index addr[5:3], offset addr[2:0]) backed by main memory.
- On an L1 miss it either bursts 8 words from memory into L2 and commits the tag, or goes straight to the L2 hit case; it then streams 4 words from L2 into L1.
- It drives the L2 refill counter and the L1 fill counter, and stalls the pipeline until the line is resident.

Parameters:
- L2_WORDS, 8, words per L2 line; the counter code L2_WORDS+1 means commit tag/valid.
- L1_WORDS, 4, words per L1 line, fetched from L2.
- CNT_W, 4, width of the L2 refill counter; must hold L2_WORDS+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- mem_read  in  1  pipeline load request.
- mem_write  in  1  pipeline store request.
- addr  in  32  request byte/word address (offset = addr[2:0]).
- l1_hit  in  1  L1 tag match for addr.
- l2_hit  in  1  L2 valid & tag match for addr.
- mem_valid  in  1  main-memory word present on the memory data bus this cycle.
- mem_req  out  1  memory burst request.
- mem_addr  out  32  {addr[31:3], word index}, critical word first.
- l2_counter  out  CNT_W  to L2: 0 = idle, 1..8 = write word at offset+counter-1, 9 = set valid and tag.
- l1_counter  out  3  L2 word index requested for the L1 fill (0..L1_WORDS-1).
- l1_fill  out  1  L1 write enable; L2 rdata is valid for slot l1_counter_d (one cycle late).
- stall  out  1  freeze the pipeline.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; wcnt=0; rcnt=0.
  - mem_req=0, mem_addr=0, l2_counter=0, l1_counter=0, l1_fill=0, busy=0.
  - stall follows only the IDLE combinational rule below.
- States: IDLE, L2_FILL, L2_COMMIT, L1_FILL, L1_DRAIN, DONE.
- IDLE:
  - stall = mem_read & !l1_hit, combinational, in the same cycle as the miss.
  - mem_read & !l1_hit & !l2_hit -> L2_FILL; latch addr into blk_addr.
  - mem_read & !l1_hit & l2_hit -> L1_FILL; latch addr.
  - mem_write is not sequenced: it passes through to the caches with no stall.
- L2_FILL:
  - mem_req=1; mem_addr={blk_addr[31:3], (blk_addr[2:0]+wcnt) mod 8}.
  - l2_counter = mem_valid ? wcnt+1 : 0. Zero while waiting, so L2 never writes garbage.
  - wcnt increments on each mem_valid.
  - When mem_valid is seen with wcnt==L2_WORDS-1 -> L2_COMMIT.
  - mem_valid in any other state is ignored.
- L2_COMMIT: one cycle; l2_counter=L2_WORDS+1 (9); mem_req=0; -> L1_FILL.
- L1_FILL:
  - l1_counter=rcnt; rcnt increments each cycle.
  - l1_fill is a one-cycle-delayed copy of the issue strobe, matching the registered L2 read.
  - After rcnt==L1_WORDS-1 -> L1_DRAIN.
- L1_DRAIN: one cycle; the last l1_fill pulse occurs here; -> DONE.
- DONE: stall=0 (the pipeline retries and now hits L1); wcnt=rcnt=0; -> IDLE.
- stall=1 in every non-IDLE state except DONE; busy=1 in every non-IDLE state.
- Stores issued while busy stay stalled; they are accepted only after DONE.
- mem_read deasserting mid-refill does not abort; the sequence runs to DONE.
- Reset mid-refill: the partially written L2 line stays invalid, because valid is set only by code 9.
- Word index arithmetic is 3-bit modulo-8 (critical word first wraps). wcnt and rcnt saturate at their terminal values, never wrap.

Decomposition:
- Package cache_ctrl_pkg holds:
  - the state encoding (3-bit localparams);
  - L2_WORDS, L1_WORDS;
  - L2_CMD_IDLE=0 and L2_CMD_COMMIT=9.
- One sub-module, burst_counter (enable, clear, terminal-count flag), instantiated twice: wcnt (terminal 7) and rcnt (terminal 3).

Test Plan:
- Cold miss, addr=0x0000_0045, mem_valid every cycle:
  - mem_addr sequence ends 5,6,7,0,1,2,3,4;
  - l2_counter 1..8, then 9;
  - 4 l1_fill pulses;
  - stall high 8+1+4+1 cycles, low at DONE.
- Same miss with mem_valid every 3rd cycle -> l2_counter is 0 on gap cycles; exactly 8 nonzero values 1..8, in order.
- L2 hit (l1_hit=0, l2_hit=1) -> no mem_req; l1_counter 0,1,2,3; l1_fill on the 4 following cycles; returns to IDLE after 6 cycles.
- rst pulled low after the 3rd mem_valid -> all outputs 0 next edge, state IDLE; the following identical read restarts at l2_counter=1 and never emits 9 early.
- mem_write=1 during L2_FILL -> stall stays 1 until DONE; mem_write in IDLE with l1_hit=1 -> stall=0, busy=0.
- mem_read dropped mid-L1_FILL -> fill completes; all 4 l1_fill pulses are still issued.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the L1/L2 read-miss refill sequencer.
// Contents: line sizes, counter widths, FSM state encoding and the
// command codes driven onto the L2 refill counter.
package cache_ctrl_pkg;

    localparam int L2_WORDS = 8;  // words per L2 line (filled from memory)
    localparam int L1_WORDS = 4;  // words per L1 line (filled from L2)
    localparam int CNT_W    = 4;  // L2 refill counter width, holds L2_WORDS+1
    localparam int IDX_W    = 3;  // word index width inside an L2 line

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_L2_FILL   = 3'd1;
    localparam logic [2:0] ST_L2_COMMIT = 3'd2;
    localparam logic [2:0] ST_L1_FILL   = 3'd3;
    localparam logic [2:0] ST_L1_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_L2_FILL   = ST_L2_FILL,
        S_L2_COMMIT = ST_L2_COMMIT,
        S_L1_FILL   = ST_L1_FILL,
        S_L1_DRAIN  = ST_L1_DRAIN,
        S_DONE      = ST_DONE
    } state_e;

    // L2 refill counter codes: 0 = no write, 1..L2_WORDS = write a word,
    // L2_WORDS+1 = set valid and tag for the line.
    localparam logic [CNT_W-1:0] L2_CMD_IDLE   = CNT_W'(0);
    localparam logic [CNT_W-1:0] L2_CMD_COMMIT = CNT_W'(L2_WORDS + 1);

endpackage

// File: rtl/burst_counter.sv
// Saturating up-counter used to sequence refill bursts.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   en_i     advance by one (holds once TERMINAL is reached)
//   clr_i    synchronous clear to zero (wins over en_i)
//   cnt_o    current count
//   tc_o     count equals TERMINAL
module burst_counter #(
    parameter int           W        = 3,
    parameter logic [W-1:0] TERMINAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o  = (cnt_q == TERMINAL);
    assign cnt_o = cnt_q;

    // Saturate rather than wrap: the FSM leaves the burst state on the
    // terminal count, so a stray extra enable must not restart the index.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Read-miss refill sequencer for a two-level cache.
// On an L1 read miss it either bursts a full L2 line in from main memory
// (critical word first) and commits the L2 tag, or goes straight to the
// L2-hit case; it then streams L1_WORDS words from L2 into L1. The
// pipeline is stalled until the line is resident in L1.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   mem_read/mem_write  pipeline load/store request
//   addr                request address (offset = addr[2:0])
//   l1_hit, l2_hit      cache lookup results for addr
//   mem_valid           memory data word present this cycle
//   mem_req, mem_addr   memory burst request and word address
//   l2_counter          L2 write command (0 idle, 1..8 word, 9 commit)
//   l1_counter          L2 word index read for the L1 fill
//   l1_fill             L1 write enable (one cycle after the L2 read issue)
//   stall, busy         pipeline freeze, sequencer active
//   dbg_state           current FSM state
//
// Handshake: memory words are accepted only in L2_FILL, one per cycle in
// which mem_valid is high; there is no backpressure toward memory.
module cache_refill_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      addr,
    input  logic             l1_hit,
    input  logic             l2_hit,
    input  logic             mem_valid,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [CNT_W-1:0] l2_counter,
    output logic [2:0]       l1_counter,
    output logic             l1_fill,
    output logic             stall,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    state_e state_q, state_d;

    logic [31:0]      blk_addr_q, blk_addr_d;
    logic             l1_fill_q, l1_fill_d;

    logic [IDX_W-1:0] wcnt, rcnt;
    logic             wcnt_tc, rcnt_tc;
    logic             wcnt_en, rcnt_en, cnt_clr;

    // Stores bypass the sequencer; while busy the pipeline holds them off
    // through stall, so the store request itself carries no state here.
    logic unused_store;
    assign unused_store = mem_write;

    burst_counter #(
        .W        (IDX_W),
        .TERMINAL (IDX_W'(L2_WORDS - 1))
    ) u_wcnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (wcnt_en),
        .clr_i (cnt_clr),
        .cnt_o (wcnt),
        .tc_o  (wcnt_tc)
    );

    burst_counter #(
        .W        (IDX_W),
        .TERMINAL (IDX_W'(L1_WORDS - 1))
    ) u_rcnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (rcnt_en),
        .clr_i (cnt_clr),
        .cnt_o (rcnt),
        .tc_o  (rcnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        blk_addr_d = blk_addr_q;
        l1_fill_d  = 1'b0;
        wcnt_en    = 1'b0;
        rcnt_en    = 1'b0;
        cnt_clr    = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        l2_counter = L2_CMD_IDLE;
        l1_counter = '0;
        stall      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Stall in the same cycle as the miss so the pipeline never
                // consumes stale data.
                stall = mem_read && !l1_hit;
                if (mem_read && !l1_hit) begin
                    blk_addr_d = addr;
                    state_d    = l2_hit ? S_L1_FILL : S_L2_FILL;
                end
            end
            S_L2_FILL: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                // Critical word first: the index wraps modulo the line size.
                mem_addr = {blk_addr_q[31:3], blk_addr_q[2:0] + wcnt};
                if (mem_valid) begin
                    // Non-zero only when a real word is on the bus.
                    l2_counter = CNT_W'(wcnt) + CNT_W'(1);
                    wcnt_en    = 1'b1;
                    if (wcnt_tc) begin
                        state_d = S_L2_COMMIT;
                    end
                end
            end
            S_L2_COMMIT: begin
                stall      = 1'b1;
                l2_counter = L2_CMD_COMMIT;
                state_d    = S_L1_FILL;
            end
            S_L1_FILL: begin
                stall      = 1'b1;
                l1_counter = rcnt;
                rcnt_en    = 1'b1;
                l1_fill_d  = 1'b1;
                if (rcnt_tc) begin
                    state_d = S_L1_DRAIN;
                end
            end
            S_L1_DRAIN: begin
                // Last registered L2 read lands in L1 this cycle.
                stall   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Release the pipeline so the retried load hits L1.
                cnt_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            blk_addr_q <= '0;
            l1_fill_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_addr_q <= blk_addr_d;
            l1_fill_q  <= l1_fill_d;
        end
    end

    // L2 reads are registered, so the L1 write enable trails the issue by one.
    assign l1_fill   = l1_fill_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic        l1_hit;
    logic        l2_hit;
    logic        mem_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  l2_counter;
    logic [2:0]  l1_counter;
    logic        l1_fill;
    logic        stall;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    cache_refill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .l1_hit     (l1_hit),
        .l2_hit     (l2_hit),
        .mem_valid  (mem_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .l2_counter (l2_counter),
        .l1_counter (l1_counter),
        .l1_fill    (l1_fill),
        .stall      (stall),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven 1 time unit after a rising edge; outputs are sampled
    // on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        l1_hit    = 1'b0;
        l2_hit    = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        addr     = 32'h0;
        rst      = 1'b0;
        next_cycle();
        mem_read = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, l1_fill, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctl: got req/fill/busy=%b want 000", {mem_req, l1_fill, busy});
        end
        n_cmp++;
        if ({mem_addr, l2_counter, l1_counter} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_bus: got addr=%h l2c=%0d l1c=%0d want 0", mem_addr, l2_counter, l1_counter);
        end
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL reset_stall_miss: got %b want 1", stall);
        end
        mem_read = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall_idle: got %b want 0", stall);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_release: got busy=%b state=%0d want 0/0", busy, dbg_state);
        end
        next_cycle();
    endtask

    // Full cold miss with a memory word every cycle.
    task automatic test_cold_miss(input logic [31:0] a);
        logic [31:0] exp_a;
        int stall_cycles;
        int fills;
        stall_cycles = 0;
        fills        = 0;
        idle_inputs();
        mem_read = 1'b1;
        addr     = a;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, stall, busy, l1_fill} !== 4'b0100) begin
            n_err++;
            $display("FAIL cold_idle: got req/stall/busy/fill=%b want 0100", {mem_req, stall, busy, l1_fill});
        end
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            mem_valid = 1'b1;
            exp_a = {a[31:3], 3'((a[2:0] + k) % 8)};
            @(negedge clk);
            if (stall) stall_cycles++;
            if (l1_fill) fills++;
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== exp_a) begin
                n_err++;
                $display("FAIL cold_addr[%0d]: got req=%b addr=%h want 1 %h", k, mem_req, mem_addr, exp_a);
            end
            n_cmp++;
            if (l2_counter !== 4'(k + 1)) begin
                n_err++;
                $display("FAIL cold_l2cnt[%0d]: got %0d want %0d", k, l2_counter, k + 1);
            end
            next_cycle();
        end
        // mem_valid left high: it must be ignored outside the fill state.
        @(negedge clk);
        if (stall) stall_cycles++;
        if (l1_fill) fills++;
        n_cmp++;
        if (l2_counter !== 4'd9 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL cold_commit: got l2c=%0d req=%b want 9 0", l2_counter, mem_req);
        end
        next_cycle();
        mem_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            if (l1_fill) fills++;
            n_cmp++;
            if (l1_counter !== 3'(j) || l2_counter !== 4'd0 || l1_fill !== (j != 0)) begin
                n_err++;
                $display("FAIL cold_l1[%0d]: got l1c=%0d l2c=%0d fill=%b want %0d 0 %b",
                         j, l1_counter, l2_counter, l1_fill, j, (j != 0));
            end
            next_cycle();
        end
        @(negedge clk);
        if (stall) stall_cycles++;
        if (l1_fill) fills++;
        n_cmp++;
        if ({l1_fill, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL cold_drain: got fill/busy=%b want 11", {l1_fill, busy});
        end
        next_cycle();
        l1_hit = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({stall, busy, l1_fill} !== 3'b010) begin
            n_err++;
            $display("FAIL cold_done: got stall/busy/fill=%b want 010", {stall, busy, l1_fill});
        end
        n_cmp++;
        if (stall_cycles != 14) begin
            n_err++;
            $display("FAIL cold_stall_count: got %0d want 14", stall_cycles);
        end
        n_cmp++;
        if (fills != 4) begin
            n_err++;
            $display("FAIL cold_fill_count: got %0d want 4", fills);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({stall, busy} !== 2'b00 || dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL cold_idle_after: got stall/busy=%b state=%0d want 00 0", {stall, busy}, dbg_state);
        end
        idle_inputs();
        next_cycle();
    endtask

    // Miss with a memory word only every third cycle.
    task automatic test_gapped_miss();
        logic [3:0]  exp_q[$];
        logic [31:0] a;
        logic [31:0] exp_a;
        int cyc;
        int fills;
        a     = 32'h1234_5673;
        fills = 0;
        for (int i = 1; i <= 8; i++) exp_q.push_back(4'(i));
        idle_inputs();
        mem_read = 1'b1;
        addr     = a;
        next_cycle();
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 60) begin
            mem_valid = (cyc % 3 == 2);
            @(negedge clk);
            if (mem_valid) begin
                exp_a = {a[31:3], 3'((3 + (8 - exp_q.size())) % 8)};
                n_cmp++;
                if (l2_counter !== exp_q[0] || mem_addr !== exp_a) begin
                    n_err++;
                    $display("FAIL gap_word: got l2c=%0d addr=%h want %0d %h", l2_counter, mem_addr, exp_q[0], exp_a);
                end
                void'(exp_q.pop_front());
            end else begin
                n_cmp++;
                if (l2_counter !== 4'd0 || mem_req !== 1'b1) begin
                    n_err++;
                    $display("FAIL gap_wait[%0d]: got l2c=%0d req=%b want 0 1", cyc, l2_counter, mem_req);
                end
            end
            cyc++;
            next_cycle();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL gap_timeout: got %0d words left want 0", exp_q.size());
        end
        mem_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (l2_counter !== 4'd9) begin
            n_err++;
            $display("FAIL gap_commit: got %0d want 9", l2_counter);
        end
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) l1_hit = 1'b1;
            @(negedge clk);
            if (l1_fill) fills++;
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (fills != 4 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL gap_finish: got fills=%0d busy=%b want 4 0", fills, busy);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_l2_hit();
        idle_inputs();
        mem_read = 1'b1;
        l2_hit   = 1'b1;
        addr     = 32'h0000_ABC8;
        @(negedge clk);
        n_cmp++;
        if ({stall, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL hit_idle: got stall/busy=%b want 10", {stall, busy});
        end
        next_cycle();
        for (int j = 0; j < 6; j++) begin
            if (j == 5) l1_hit = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (mem_req !== 1'b0 || l2_counter !== 4'd0) begin
                n_err++;
                $display("FAIL hit_no_mem[%0d]: got req=%b l2c=%0d want 0 0", j, mem_req, l2_counter);
            end
            if (j < 4) begin
                n_cmp++;
                if (l1_counter !== 3'(j) || l1_fill !== (j != 0) || stall !== 1'b1) begin
                    n_err++;
                    $display("FAIL hit_l1[%0d]: got l1c=%0d fill=%b stall=%b want %0d %b 1",
                             j, l1_counter, l1_fill, stall, j, (j != 0));
                end
            end else if (j == 4) begin
                n_cmp++;
                if ({l1_fill, stall} !== 2'b11) begin
                    n_err++;
                    $display("FAIL hit_drain: got fill/stall=%b want 11", {l1_fill, stall});
                end
            end else begin
                n_cmp++;
                if ({stall, busy, l1_fill} !== 3'b010) begin
                    n_err++;
                    $display("FAIL hit_done: got stall/busy/fill=%b want 010", {stall, busy, l1_fill});
                end
            end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL hit_back_idle: got busy=%b state=%0d want 0 0", busy, dbg_state);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_fill();
        idle_inputs();
        mem_read = 1'b1;
        addr     = 32'h0000_0045;
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            mem_valid = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (l2_counter !== 4'(k + 1)) begin
                n_err++;
                $display("FAIL rst_pre[%0d]: got %0d want %0d", k, l2_counter, k + 1);
            end
            next_cycle();
        end
        rst      = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, l1_fill, busy, stall} !== 4'b0000 || {mem_addr, l2_counter, l1_counter} !== 39'd0) begin
            n_err++;
            $display("FAIL rst_mid: got req/fill/busy/stall=%b addr=%h l2c=%0d l1c=%0d want all 0",
                     {mem_req, l1_fill, busy, stall}, mem_addr, l2_counter, l1_counter);
        end
        n_cmp++;
        if (dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL rst_mid_state: got %0d want 0", dbg_state);
        end
        next_cycle();
        rst       = 1'b1;
        mem_valid = 1'b0;
        next_cycle();
        test_cold_miss(32'h0000_0045);
    endtask

    task automatic test_store_stall();
        idle_inputs();
        mem_read = 1'b1;
        addr     = 32'h0000_0100;
        next_cycle();
        mem_read  = 1'b0;
        mem_write = 1'b1;
        for (int i = 0; i < 14; i++) begin
            mem_valid = (i < 8);
            @(negedge clk);
            n_cmp++;
            if (stall !== 1'b1 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL store_stall[%0d]: got stall=%b busy=%b want 1 1", i, stall, busy);
            end
            next_cycle();
        end
        mem_valid = 1'b0;
        l1_hit    = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({stall, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL store_done: got stall/busy=%b want 01", {stall, busy});
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({stall, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL store_idle_hit: got stall/busy=%b want 00", {stall, busy});
        end
        next_cycle();
        l1_hit = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({stall, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL store_idle_miss: got stall/busy=%b want 00", {stall, busy});
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL store_not_sequenced: got busy=%b req=%b want 0 0", busy, mem_req);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_read_drop();
        int fills;
        fills = 0;
        idle_inputs();
        mem_read = 1'b1;
        l2_hit   = 1'b1;
        addr     = 32'h0000_0F38;
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                mem_read = 1'b0;
                l2_hit   = 1'b0;
            end
            @(negedge clk);
            if (l1_fill) fills++;
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (fills != 4) begin
            n_err++;
            $display("FAIL drop_fills: got %0d want 4", fills);
        end
        n_cmp++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL drop_idle: got busy=%b stall=%b want 0 0", busy, stall);
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        addr = 32'h0;
        rst  = 1'b0;
        test_reset();
        test_cold_miss(32'h0000_0045);
        test_gapped_miss();
        test_l2_hit();
        test_reset_mid_fill();
        test_store_stall();
        test_read_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
